mem_resp_mc: RTL and testbench
==============================

Name: mem_resp_mc

Overview:
- Multicycle data-memory responder: the memory end of the CPU's data-memory interface (enable / wr / addr / data_in / data_out).
- Accepts one request at a time, holds it for a fixed latency, then commits the write or returns the read word with a one-cycle data_valid pulse.
- Intended as the stall-capable replacement for the single-cycle data memory, on the same clk / rst as the core.

Parameters:
- DATA_WIDTH, 16, word width in bits.
- ADDR_WIDTH, 16, byte-address width.
- DEPTH_LOG2, 10, log2 of the number of words (1024 words).
- LATENCY, 4, rising edges from the accept edge (inclusive) to the edge that raises data_valid; legal values >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  request strobe.
- wr  in  1  1 = write, 0 = read; sampled with enable.
- addr  in  ADDR_WIDTH  byte address; word index = addr[DEPTH_LOG2:1]; addr[0] and bits above DEPTH_LOG2 are ignored (aliasing).
- data_in  in  DATA_WIDTH  write data, sampled at accept.
- data_out  out  DATA_WIDTH  read data; held until the next read completes.
- data_valid  out  1  one-cycle completion pulse, for both reads and writes.
- busy  out  1  request in flight; new requests are ignored while high.
- err  out  1  alignment-error pulse (see Optional Feature); tied 0 when the feature is off.

Behaviour:
- Reset (async, rst=1):
  - busy=0, data_valid=0, data_out=0, err=0; state IDLE; counter=0.
  - Memory array is not cleared.
  - Reset during WAIT aborts the request: no array write, no data_valid pulse.
- States:
  - IDLE: at a rising edge with enable=1 and busy=0 (accept edge E0), latch wr, word index and data_in; load counter with LATENCY-1; go to WAIT; busy=1 from E0.
  - WAIT: counter decrements each edge. At the edge where counter==1 (edge E(LATENCY-1)):
    - write: array[idx] <= latched data.
    - read: data_out <= array[idx].
    - data_valid=1, busy=0, go to DONE.
  - DONE: lasts one cycle. data_valid=1, busy=0. The next edge clears data_valid and returns to IDLE.
  - DONE accepts exactly as IDLE: enable=1 at that edge starts a new request directly (back-to-back throughput of one request per LATENCY cycles).
- Latency: with LATENCY=4, accept at E0 -> data_valid high in the cycle after E3; data_out valid in that same cycle.
- enable=1 while busy=1 is ignored: not queued, and latched fields do not change. The requester must hold or re-issue after data_valid.
- data_out changes only at read completion; write completion leaves it untouched.
- Read-after-write to the same word, back to back: the read returns the newly written data.
- data_valid is never asserted for two consecutive cycles unless a new request was accepted in DONE and LATENCY==2 — impossible by construction. For LATENCY>=2, pulses are separated by at least one low cycle.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - A request with addr[0]=1 is rejected at the accept edge: no state change, busy stays 0, no array access.
  - err=1 for exactly the one cycle following that edge; data_valid is not pulsed.
- Undefined:
  - addr[0] is ignored (the word is accessed as if aligned).
  - err is constant 0.

Test Plan:
- Reset: rst=1 mid-cycle with no clock edge -> busy=0, data_valid=0, data_out=0 immediately.
- Write then read: write 0xBEEF to addr 0x0010 (accept E0) -> data_valid at cycle after E3, busy low from then. Read addr 0x0010 accepted at next edge -> data_valid 4 edges later with data_out=0xBEEF.
- Busy ignore: read 0x0020 (contains 0x1234) accepted; pulse enable with wr=1, addr 0x0020, data 0xFFFF two cycles later -> data_out=0x1234, and a later read of 0x0020 returns 0x1234 (the write was ignored).
- Aliasing: write 0xA5A5 to 0x0802 (DEPTH_LOG2=10) -> a read of 0x0002 returns 0xA5A5.
- Reset mid-op: write 0x5555 to 0x0030 (old value 0x0000), assert rst after E1 -> no data_valid; after release, a read of 0x0030 returns 0x0000.
- MEM_ALIGN_CHECK_EN defined: read addr 0x0011 -> err=1 for one cycle, busy=0, no data_valid. With the macro undefined, the same request returns the word at 0x0010.

Source files
------------

// File: rtl/mem_resp_mc.sv
// rtl/mem_resp_mc.sv - multicycle data-memory responder with fixed completion latency
// Optional alignment rejection is built when MEM_ALIGN_CHECK_EN is defined.
module mem_resp_mc #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  wr_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] data_in_i,
  output logic [DATA_WIDTH-1:0] data_out_o,
  output logic                  data_valid_o,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int CW = $clog2(LATENCY) + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t                  state_q;
  logic [CW-1:0]           cnt_q;
  logic                    wr_q;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    valid_q;
  logic                    busy_q;
  logic                    err_q;
  logic [DATA_WIDTH-1:0]   mem_q [0:(1<<DEPTH_LOG2)-1];

  logic                    misaligned_d;
  logic                    accept_d;
  logic                    complete_d;
  logic                    mem_we_d;
  logic [DEPTH_LOG2-1:0]   idx_d;
  logic                    addr_unused;

  // Upper address bits alias onto the array; the byte bit only matters for the check.
  assign idx_d       = addr_i[DEPTH_LOG2:1];
  assign addr_unused = ^{addr_i[ADDR_WIDTH-1:DEPTH_LOG2+1], addr_i[0]};

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned_d = addr_i[0];
`else
  assign misaligned_d = 1'b0;
`endif

  assign accept_d   = enable_i && (state_q != S_WAIT) && !misaligned_d;
  assign complete_d = (state_q == S_WAIT) && (cnt_q == CW'(1));
  assign mem_we_d   = complete_d && wr_q;

  // Array is deliberately outside the reset domain so reset never clears it.
  always_ff @(posedge clk_i) begin
    if (mem_we_d) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (accept_d) begin
            wr_q    <= wr_i;
            idx_q   <= idx_d;
            wdata_q <= data_in_i;
            cnt_q   <= CW'(LATENCY - 1);
            busy_q  <= 1'b1;
            state_q <= S_WAIT;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
            if (enable_i && misaligned_d) begin
              err_q <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (complete_d) begin
            if (!wr_q) begin
              rdata_q <= mem_q[idx_q];
            end
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign data_out_o   = rdata_q;
  assign data_valid_o = valid_q;
  assign busy_o       = busy_q;
`ifdef MEM_ALIGN_CHECK_EN
  assign err_o        = err_q;
`else
  assign err_o        = 1'b0;
`endif

endmodule

// File: tb/tb_mem_resp_mc.sv
// tb/tb_mem_resp_mc.sv - directed self-checking bench for mem_resp_mc (LATENCY=4)
module tb_mem_resp_mc;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        wr;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        data_valid;
  logic        busy;
  logic        err;

  int tests_run;
  int tests_failed;

  mem_resp_mc #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(16),
    .DEPTH_LOG2(10),
    .LATENCY   (4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .enable_i    (enable),
    .wr_i        (wr),
    .addr_i      (addr),
    .data_in_i   (data_in),
    .data_out_o  (data_out),
    .data_valid_o(data_valid),
    .busy_o      (busy),
    .err_o       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance n rising edges and settle 2 time units past the last one.
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Present a request, let one edge accept it, then drop enable (returns at E0+2).
  task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d);
    enable  = 1'b1;
    wr      = w;
    addr    = a;
    data_in = d;
    @(posedge clk);
    #2;
    enable = 1'b0;
  endtask

  task automatic run_req(input logic w, input logic [15:0] a, input logic [15:0] d);
    issue(w, a, d);
    edges(4);
  endtask

  task automatic test_reset;
    rst = 1'b1; enable = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
    #3;
    tests_run++;
    if (busy !== 1'b0 || data_valid !== 1'b0 || data_out !== 16'h0 || err !== 1'b0) begin
      $display("FAIL reset_state busy=%b dv=%b dout=%h err=%b expected 0/0/0000/0", busy, data_valid, data_out, err);
      tests_failed++;
    end
    #9;
    rst = 1'b0;
    edges(1);
    tests_run++;
    if (busy !== 1'b0 || data_valid !== 1'b0) begin
      $display("FAIL reset_release busy=%b dv=%b expected 0/0", busy, data_valid);
      tests_failed++;
    end
  endtask

  task automatic test_write_read;
    issue(1'b1, 16'h0010, 16'hBEEF);
    tests_run++;
    if (busy !== 1'b1 || data_valid !== 1'b0) begin
      $display("FAIL wr_accept busy=%b dv=%b expected 1/0", busy, data_valid);
      tests_failed++;
    end
    edges(2);
    tests_run++;
    if (busy !== 1'b1 || data_valid !== 1'b0) begin
      $display("FAIL wr_e2 busy=%b dv=%b expected 1/0", busy, data_valid);
      tests_failed++;
    end
    edges(1);
    tests_run++;
    if (busy !== 1'b0 || data_valid !== 1'b1 || data_out !== 16'h0000) begin
      $display("FAIL wr_done busy=%b dv=%b dout=%h expected 0/1/0000", busy, data_valid, data_out);
      tests_failed++;
    end
    issue(1'b0, 16'h0010, 16'h0000);
    tests_run++;
    if (busy !== 1'b1 || data_valid !== 1'b0) begin
      $display("FAIL rd_accept_in_done busy=%b dv=%b expected 1/0", busy, data_valid);
      tests_failed++;
    end
    edges(3);
    tests_run++;
    if (data_valid !== 1'b1 || data_out !== 16'hBEEF || busy !== 1'b0) begin
      $display("FAIL rd_done dv=%b dout=%h busy=%b expected 1/beef/0", data_valid, data_out, busy);
      tests_failed++;
    end
    edges(1);
    tests_run++;
    if (data_valid !== 1'b0 || data_out !== 16'hBEEF) begin
      $display("FAIL rd_after dv=%b dout=%h expected 0/beef", data_valid, data_out);
      tests_failed++;
    end
  endtask

  task automatic test_busy_ignore;
    run_req(1'b1, 16'h0020, 16'h1234);
    issue(1'b0, 16'h0020, 16'h0000);
    edges(1);
    enable = 1'b1; wr = 1'b1; addr = 16'h0020; data_in = 16'hFFFF;
    edges(1);
    enable = 1'b0;
    tests_run++;
    if (busy !== 1'b1) begin
      $display("FAIL busy_hold busy=%b expected 1", busy);
      tests_failed++;
    end
    edges(1);
    tests_run++;
    if (data_valid !== 1'b1 || data_out !== 16'h1234) begin
      $display("FAIL busy_rd dv=%b dout=%h expected 1/1234", data_valid, data_out);
      tests_failed++;
    end
    edges(1);
    run_req(1'b0, 16'h0020, 16'h0000);
    tests_run++;
    if (data_out !== 16'h1234) begin
      $display("FAIL busy_write_ignored dout=%h expected 1234", data_out);
      tests_failed++;
    end
  endtask

  task automatic test_alias;
    run_req(1'b1, 16'h0802, 16'hA5A5);
    run_req(1'b0, 16'h0002, 16'h0000);
    tests_run++;
    if (data_out !== 16'hA5A5) begin
      $display("FAIL alias dout=%h expected a5a5", data_out);
      tests_failed++;
    end
  endtask

  task automatic test_reset_mid_op;
    int dv_seen;
    run_req(1'b1, 16'h0030, 16'h0000);
    issue(1'b1, 16'h0030, 16'h5555);
    edges(1);
    rst = 1'b1;
    #1;
    tests_run++;
    if (busy !== 1'b0 || data_valid !== 1'b0) begin
      $display("FAIL rst_mid_async busy=%b dv=%b expected 0/0", busy, data_valid);
      tests_failed++;
    end
    edges(1);
    rst = 1'b0;
    dv_seen = 0;
    for (int i = 0; i < 5; i++) begin
      edges(1);
      if (data_valid === 1'b1) dv_seen++;
    end
    tests_run++;
    if (dv_seen != 0) begin
      $display("FAIL rst_mid_no_valid pulses=%0d expected 0", dv_seen);
      tests_failed++;
    end
    run_req(1'b0, 16'h0030, 16'h0000);
    tests_run++;
    if (data_out !== 16'h0000) begin
      $display("FAIL rst_mid_no_write dout=%h expected 0000", data_out);
      tests_failed++;
    end
  endtask

  task automatic test_back_to_back;
    issue(1'b1, 16'h0040, 16'h1111);
    edges(3);
    issue(1'b0, 16'h0040, 16'h0000);
    tests_run++;
    if (data_valid !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL b2b_gap dv=%b busy=%b expected 0/1", data_valid, busy);
      tests_failed++;
    end
    edges(3);
    tests_run++;
    if (data_valid !== 1'b1 || data_out !== 16'h1111) begin
      $display("FAIL b2b_raw dv=%b dout=%h expected 1/1111", data_valid, data_out);
      tests_failed++;
    end
    edges(1);
  endtask

  task automatic test_reset_busy;
    issue(1'b0, 16'h0010, 16'h0000);
    edges(1);
    rst = 1'b1;
    #1;
    tests_run++;
    if (busy !== 1'b0 || data_valid !== 1'b0 || data_out !== 16'h0000) begin
      $display("FAIL rst_async busy=%b dv=%b dout=%h expected 0/0/0000", busy, data_valid, data_out);
      tests_failed++;
    end
    edges(1);
    rst = 1'b0;
    edges(1);
  endtask

  task automatic test_align;
    issue(1'b0, 16'h0011, 16'h0000);
`ifdef MEM_ALIGN_CHECK_EN
    tests_run++;
    if (err !== 1'b1 || busy !== 1'b0 || data_valid !== 1'b0) begin
      $display("FAIL align_reject err=%b busy=%b dv=%b expected 1/0/0", err, busy, data_valid);
      tests_failed++;
    end
    edges(1);
    tests_run++;
    if (err !== 1'b0 || data_valid !== 1'b0) begin
      $display("FAIL align_pulse err=%b dv=%b expected 0/0", err, data_valid);
      tests_failed++;
    end
`else
    tests_run++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL align_off_accept err=%b busy=%b expected 0/1", err, busy);
      tests_failed++;
    end
    edges(3);
    tests_run++;
    if (data_valid !== 1'b1 || data_out !== 16'hBEEF) begin
      $display("FAIL align_off_read dv=%b dout=%h expected 1/beef", data_valid, data_out);
      tests_failed++;
    end
    edges(1);
`endif
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_write_read();
    test_busy_ignore();
    test_alias();
    test_reset_mid_op();
    test_back_to_back();
    test_reset_busy();
    test_align();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
